data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Arbitrates CORE_COUNT cores onto one single-port data memory: IDLE -> ISSUE -> RESP per access.
// Round-robin by default; define DATA_MEM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module data_mem_arbiter #(
   parameter int CORE_COUNT          = 4,
   parameter int REG_WIDTH           = 12,
   parameter int DATA_MEM_ADDR_WIDTH = 12
) (
   input  logic                                      clk,
   input  logic                                      rstN,
   input  logic [CORE_COUNT-1:0]                     coreReq,
   input  logic [CORE_COUNT-1:0]                     coreWrEn,
   input  logic [DATA_MEM_ADDR_WIDTH*CORE_COUNT-1:0] coreAddr,
   input  logic [REG_WIDTH*CORE_COUNT-1:0]           coreDataIn,
   output logic [CORE_COUNT-1:0]                     coreAck,
   output logic [REG_WIDTH-1:0]                      coreDataOut,
   output logic [DATA_MEM_ADDR_WIDTH-1:0]            memAddr,
   output logic [REG_WIDTH-1:0]                      memDataIn,
   output logic                                      memWrEn,
   input  logic [REG_WIDTH-1:0]                      memDataOut,
   output logic                                      busy
);

   localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                         state;
   logic [IDX_W-1:0]               win_idx;
   logic                           win_wr;
   logic [IDX_W-1:0]               grant_idx;
   logic [DATA_MEM_ADDR_WIDTH-1:0] addr_arr [CORE_COUNT];
   logic [REG_WIDTH-1:0]           data_arr [CORE_COUNT];

   for (genvar g = 0; g < CORE_COUNT; g++) begin : g_unpack
      assign addr_arr[g] = coreAddr[DATA_MEM_ADDR_WIDTH*g +: DATA_MEM_ADDR_WIDTH];
      assign data_arr[g] = coreDataIn[REG_WIDTH*g +: REG_WIDTH];
   end

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
   function automatic logic [IDX_W-1:0] pick_fixed(input logic [CORE_COUNT-1:0] req);
      pick_fixed = '0;
      for (int i = CORE_COUNT - 1; i >= 0; i--) begin
         if (req[i]) pick_fixed = IDX_W'(i);
      end
   endfunction

   assign grant_idx = pick_fixed(coreReq);
`else
   logic [IDX_W-1:0] ptr;

   // First requester at or after base, scanning upward with wrap.
   function automatic logic [IDX_W-1:0] pick_rr(input logic [CORE_COUNT-1:0] req,
                                                input logic [IDX_W-1:0]      base);
      logic [IDX_W:0] cand;
      logic           found;
      pick_rr = base;
      found   = 1'b0;
      for (int off = 0; off < CORE_COUNT; off++) begin
         cand = {1'b0, base} + (IDX_W+1)'(off);
         if (cand >= (IDX_W+1)'(CORE_COUNT)) cand = cand - (IDX_W+1)'(CORE_COUNT);
         if (!found && req[cand[IDX_W-1:0]]) begin
            found   = 1'b1;
            pick_rr = cand[IDX_W-1:0];
         end
      end
   endfunction

   assign grant_idx = pick_rr(coreReq, ptr);
`endif

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state       <= IDLE;
         busy        <= 1'b0;
         win_idx     <= '0;
         win_wr      <= 1'b0;
         coreAck     <= '0;
         coreDataOut <= '0;
         memAddr     <= '0;
         memDataIn   <= '0;
         memWrEn     <= 1'b0;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
         ptr         <= '0;
`endif
      end else begin
         coreAck <= '0;
         memWrEn <= 1'b0;
         case (state)
            IDLE: begin
               if (|coreReq) begin
                  state     <= ISSUE;
                  busy      <= 1'b1;
                  win_idx   <= grant_idx;
                  win_wr    <= coreWrEn[grant_idx];
                  memAddr   <= addr_arr[grant_idx];
                  memDataIn <= data_arr[grant_idx];
                  // Registered here so the strobe is high for exactly the ISSUE cycle.
                  memWrEn   <= coreWrEn[grant_idx];
               end
            end
            ISSUE: begin
               state <= RESP;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
               ptr   <= (win_idx == IDX_W'(CORE_COUNT - 1)) ? '0 : win_idx + 1'b1;
`endif
            end
            RESP: begin
               state            <= IDLE;
               busy             <= 1'b0;
               coreAck[win_idx] <= 1'b1;
               if (!win_wr) coreDataOut <= memDataOut;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: arbitration model predicts grants, monitor checks memory strobes and acks.
module tb_data_mem_arbiter;

   localparam int N  = 4;
   localparam int RW = 12;
   localparam int AW = 12;

   logic              clk;
   logic              rstN;
   logic [N-1:0]      coreReq;
   logic [N-1:0]      coreWrEn;
   logic [AW*N-1:0]   coreAddr;
   logic [RW*N-1:0]   coreDataIn;
   logic [N-1:0]      coreAck;
   logic [RW-1:0]     coreDataOut;
   logic [AW-1:0]     memAddr;
   logic [RW-1:0]     memDataIn;
   logic              memWrEn;
   logic [RW-1:0]     memDataOut;
   logic              busy;

   data_mem_arbiter #(.CORE_COUNT(N), .REG_WIDTH(RW), .DATA_MEM_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstN(rstN), .coreReq(coreReq), .coreWrEn(coreWrEn), .coreAddr(coreAddr),
      .coreDataIn(coreDataIn), .coreAck(coreAck), .coreDataOut(coreDataOut), .memAddr(memAddr),
      .memDataIn(memDataIn), .memWrEn(memWrEn), .memDataOut(memDataOut), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory with one-cycle read latency.
   logic [RW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (memWrEn) mem[memAddr] <= memDataIn;
      memDataOut <= mem[memAddr];
   end

   typedef struct { int core; bit wr; int addr; int data; int k; int ack; } exp_t;
   typedef struct { int core; int edge_no; int data; } hist_t;

   exp_t  q[$];
   hist_t hist[$];
   int    ref_mem [0:(1<<AW)-1];
   int    edge_cnt = 0;
   int    free_at  = 0;
   int    ptr      = 0;
   int    last_dout = 0;
   int    n_chk = 0;
   int    n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      int t;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      for (int n = 0; n < N; n++) begin
         t = n;
         if (r[t[1:0]]) return t;
      end
`else
      for (int n = 0; n < N; n++) begin
         t = (p + n) % N;
         if (r[t[1:0]]) return t;
      end
`endif
      return -1;
   endfunction

   // Reference model: an arbitration opportunity exists every edge once the previous access is 3 edges old.
   initial forever begin
      @(posedge clk);
      if (rstN) begin
         edge_cnt++;
         if (edge_cnt >= free_at && coreReq != 0) begin
            exp_t e;
            e.core = pick(coreReq, ptr);
            e.wr   = coreWrEn[e.core];
            e.addr = int'(coreAddr[AW*e.core +: AW]);
            e.data = int'(coreDataIn[RW*e.core +: RW]);
            e.k    = edge_cnt;
            e.ack  = edge_cnt + 2;
            q.push_back(e);
            ptr     = (e.core + 1) % N;
            free_at = edge_cnt + 3;
         end
      end
   end

   initial forever begin
      @(negedge rstN);
      q.delete();
      ptr       = 0;
      free_at   = 0;
      last_dout = 0;
   end

   // Monitor
   initial forever begin
      @(negedge clk);
      if (rstN === 1'b1) begin
         if (q.size() > 0) begin
            exp_t e;
            e = q[0];
            if (edge_cnt == e.k) begin
               chk("issue_wren", int'(memWrEn), int'(e.wr));
               chk("issue_addr", int'(memAddr), e.addr);
               if (e.wr) chk("issue_wdata", int'(memDataIn), e.data);
            end else begin
               chk("wren_idle", int'(memWrEn), 0);
            end
            chk("busy", int'(busy), (edge_cnt < e.ack) ? 1 : 0);
            if (edge_cnt == e.ack) begin
               hist_t h;
               chk("ack_core", int'(coreAck), 1 << e.core);
               if (e.wr) begin
                  chk("dout_hold", int'(coreDataOut), last_dout);
                  ref_mem[e.addr] = e.data;
               end else begin
                  chk("read_data", int'(coreDataOut), ref_mem[e.addr]);
                  last_dout = ref_mem[e.addr];
               end
               h.core = e.core; h.edge_no = edge_cnt; h.data = int'(coreDataOut);
               hist.push_back(h);
               void'(q.pop_front());
            end else begin
               chk("ack_quiet", int'(coreAck), 0);
            end
         end else begin
            chk("idle_ack", int'(coreAck), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_wren", int'(memWrEn), 0);
         end
      end
   end

   task automatic set_req(input int i, input bit wr, input int addr, input int data);
      coreReq[i]              = 1'b1;
      coreWrEn[i]             = wr;
      coreAddr[AW*i +: AW]    = AW'(addr);
      coreDataIn[RW*i +: RW]  = RW'(data);
   endtask

   task automatic wait_acks(input int n, input int limit);
      int target;
      int cnt;
      target = hist.size() + n;
      cnt = 0;
      while (hist.size() < target && cnt < limit) begin
         @(negedge clk); #1;
         cnt++;
      end
      chk("ack_timeout", (hist.size() >= target) ? 1 : 0, 1);
   endtask

   task automatic wait_grant(input int limit);
      int cnt;
      cnt = 0;
      while (q.size() == 0 && cnt < limit) begin
         @(negedge clk); #1;
         cnt++;
      end
      chk("grant_timeout", (q.size() > 0) ? 1 : 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ack"},   int'(coreAck), 0);
      chk({tag, "_dout"},  int'(coreDataOut), 0);
      chk({tag, "_addr"},  int'(memAddr), 0);
      chk({tag, "_wdata"}, int'(memDataIn), 0);
      chk({tag, "_wren"},  int'(memWrEn), 0);
      chk({tag, "_busy"},  int'(busy), 0);
   endtask

   int exp_order [6];
   int base;
   int hsz;

   initial begin
      for (int a = 0; a < (1<<AW); a++) begin
         mem[a]     = '0;
         ref_mem[a] = 0;
      end
      rstN = 1'b0;
      coreReq = '0; coreWrEn = '0; coreAddr = '0; coreDataIn = '0;
      // All four cores request from reset with reads of distinct addresses.
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 16 + i, 0);
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk); #2 rstN = 1'b1;

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0, 1};
`endif
      wait_acks(6, 60);
      coreReq = '0;
      for (int j = 0; j < 6 && j < hist.size(); j++) begin
         chk("all_req_order", hist[j].core, exp_order[j]);
         if (j > 0) chk("all_req_spacing", hist[j].edge_no - hist[j-1].edge_no, 3);
      end
      repeat (4) @(negedge clk); #1;

      // Core 2 writes 0xABC to 0x010, then keeps requesting as a read.
      set_req(2, 1'b1, 'h010, 'hABC);
      wait_acks(1, 20);
      set_req(2, 1'b0, 'h010, 0);
      wait_acks(1, 20);
      coreReq = '0;
      base = hist.size();
      if (base >= 2) begin
         chk("wr_rd_core", hist[base-1].core, 2);
         chk("wr_rd_data", hist[base-1].data, 'hABC);
         chk("wr_rd_spacing", hist[base-1].edge_no - hist[base-2].edge_no, 3);
      end
      repeat (3) @(negedge clk); #1;

      // Pointer now sits at 3: cores 1 and 3 contend.
      set_req(1, 1'b0, 'h001, 0);
      set_req(3, 1'b0, 'h003, 0);
      wait_acks(1, 20);
      coreReq[hist[hist.size()-1].core] = 1'b0;
      wait_acks(1, 20);
      coreReq = '0;
      base = hist.size();
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      chk("wrap_first",  hist[base-2].core, 1);
      chk("wrap_second", hist[base-1].core, 3);
`else
      chk("wrap_first",  hist[base-2].core, 3);
      chk("wrap_second", hist[base-1].core, 1);
`endif
      repeat (3) @(negedge clk); #1;

      // Core 0 withdraws its request during ISSUE; the access still completes.
      set_req(0, 1'b0, 'h010, 0);
      wait_grant(20);
      coreReq[0] = 1'b0;
      wait_acks(1, 20);
      chk("drop_core", hist[hist.size()-1].core, 0);
      chk("drop_data", hist[hist.size()-1].data, 'hABC);
      repeat (3) @(negedge clk); #1;

      // Reset during ISSUE of a core 1 write aborts it.
      set_req(1, 1'b1, 'h020, 'h555);
      wait_grant(20);
      chk("abort_wren_before", int'(memWrEn), 1);
      #1 rstN = 1'b0;
      #1 check_reset_outputs("abort");
      coreReq = '0;
      hsz = hist.size();
      @(posedge clk);
      @(negedge clk); #2 rstN = 1'b1;
      repeat (4) @(negedge clk); #1;
      chk("abort_no_ack", hist.size(), hsz);

      // First arbitration after reset starts at index 0; the aborted write left 0x020 untouched.
      set_req(0, 1'b0, 'h020, 0);
      set_req(2, 1'b0, 'h010, 0);
      wait_acks(1, 20);
      coreReq[0] = 1'b0;
      wait_acks(1, 20);
      coreReq = '0;
      base = hist.size();
      chk("post_reset_first", hist[base-2].core, 0);
      chk("post_reset_data",  hist[base-2].data, 0);
      chk("post_reset_second", hist[base-1].core, 2);

      // Randomised traffic from four independent cores.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (coreAck[i]) begin
               if ($urandom_range(1, 0) == 1)
                  set_req(i, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom_range(4095, 0)));
               else
                  coreReq[i] = 1'b0;
            end else if (coreReq[i] && q.size() > 0 && q[0].core == i && q[0].k == edge_cnt) begin
               if ($urandom_range(3, 0) == 0) coreReq[i] = 1'b0;
            end else if (!coreReq[i] && !(q.size() > 0 && q[0].core == i)) begin
               if ($urandom_range(3, 0) == 0)
                  set_req(i, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom_range(4095, 0)));
            end
         end
      end
      coreReq = '0;
      for (int d = 0; d < 20 && q.size() > 0; d++) @(negedge clk);
      #1 chk("drain_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
